shift_seq: RTL

//  Multi-cycle sequencer for the ALU shift datapath. Accepts one shift request
//  per transaction over a valid/ready handshake. Applies one barrel-shifter mux

---
 rtl/shift_seq.sv | 100 ++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one reused barrel-shifter mux layer per clock, LSB layer first.
// Optional SHIFT_EARLY_EXIT_EN: leave SHIFT once no higher shamt bits remain.
module shift_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   shamt,
   input  logic             flush,
   output logic             busy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt, hmask;
   logic [1:0]       op_r;
   logic [SHW-1:0]   shamt_r, layer, hi;
   logic             sign_r, last_layer, accept;
   logic [SHW:0]     amt, ramt;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = acc;
   assign accept    = in_valid & in_ready & ~flush;

   assign amt   = (SHW+1)'(1) << layer;
   assign ramt  = (SHW+1)'(WIDTH) - amt;
   assign hmask = ~({WIDTH{1'b1}} >> amt);
   assign hi    = shamt_r >> layer;

`ifdef SHIFT_EARLY_EXIT_EN
   assign last_layer = ((hi >> 1) == '0) || (layer == SHW'(SHW-1));
`else
   assign last_layer = (layer == SHW'(SHW-1));
`endif

   // SRA fills from the sign captured at accept, so later layers stay correct
   always_comb begin
      acc_nxt = acc;
      if (shamt_r[layer]) begin
         case (op_r)
            2'b00:   acc_nxt = acc << amt;
            2'b01:   acc_nxt = acc >> amt;
            2'b10:   acc_nxt = (acc >> amt) | ({WIDTH{sign_r}} & hmask);
            default: acc_nxt = (acc << amt) | (acc >> ramt);
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_layer) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         op_r    <= '0;
         shamt_r <= '0;
         sign_r  <= 1'b0;
         layer   <= '0;
      end else if (flush) begin
         layer   <= '0;
      end else if (accept) begin
         acc     <= in_data;
         op_r    <= op;
         shamt_r <= shamt;
         sign_r  <= in_data[WIDTH-1];
         layer   <= '0;
      end else if (state == SHIFT) begin
         acc     <= acc_nxt;
         layer   <= last_layer ? '0 : layer + SHW'(1);
      end
   end

endmodule
